// File: rtl/lock_controller_pkg.sv
// Shared definitions for the lock chamber controller: FSM state encoding and
// chamber side constants, used by the RTL and by the bench.
package lock_controller_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        MOVE_EMPTY = 4'd1,
        OPEN_IN    = 4'd2,
        WAIT_IN    = 4'd3,
        CLOSE_IN   = 4'd4,
        MOVE_FULL  = 4'd5,
        OPEN_OUT   = 4'd6,
        WAIT_OUT   = 4'd7,
        CLOSE_OUT  = 4'd8
    } state_t;

    localparam int   STATE_W   = 4;
    localparam logic SIDE_LOW  = 1'b0;
    localparam logic SIDE_HIGH = 1'b1;

endpackage

// File: rtl/lock_controller_level_timer.sv
// Chamber water level: STEP_CYCLES prescaler driving an up/down counter that
// saturates at 0 (draining, dir=0) and LEVEL_MAX (filling, dir=1).
module lock_controller_level_timer #(
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_MAX   = 8,
    parameter int STEP_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               dir,
    output logic [LEVEL_W-1:0] level,
    output logic               at_target
);

    localparam int PW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);
    localparam logic [PW-1:0]      PRESC_LAST = PW'(STEP_CYCLES - 1);

    logic [PW-1:0] presc;

    assign at_target = dir ? (level == LEVEL_TOP) : (level == '0);

    // Prescaler restarts on every move, so a full move is LEVEL_MAX*STEP_CYCLES cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc <= '0;
            level <= '0;
        end else if (!en || at_target) begin
            presc <= '0;
        end else if (presc == PRESC_LAST) begin
            presc <= '0;
            level <= dir ? level + LEVEL_W'(1) : level - LEVEL_W'(1);
        end else begin
            presc <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/lock_controller.sv
// Two-gate lock chamber sequencer. Optional enter timeout in WAIT_IN is built
// when the macro TIMEOUT_EN is defined; otherwise timeout is tied low.
module lock_controller
    import lock_controller_pkg::*;
#(
    parameter int LEVEL_W     = 4,
    parameter int LEVEL_MAX   = 8,
    parameter int STEP_CYCLES = 4
`ifdef TIMEOUT_EN
    ,
    parameter int ENTER_TIMEOUT = 64
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               up_req,
    input  logic               down_req,
    input  logic               occupied,
    input  logic               low_status,
    input  logic               high_status,
    output logic               low_open,
    output logic               low_close,
    output logic               high_open,
    output logic               high_close,
    output logic [LEVEL_W-1:0] level,
    output logic               busy,
    output logic               timeout,
    output logic [STATE_W-1:0] dbg_state,
    output logic               dbg_at_high
);

    localparam logic [LEVEL_W-1:0] LEVEL_TOP = LEVEL_W'(LEVEL_MAX);

    state_t state, state_next;
    logic   at_high, at_high_next;
    logic   is_high, cur_status, other_status, level_ok;
    logic   move_en, at_target;
    logic   open_cur, close_cur, close_other;

    // Everything is expressed relative to the side the chamber currently serves.
    assign is_high      = (at_high == SIDE_HIGH);
    assign cur_status   = is_high ? high_status : low_status;
    assign other_status = is_high ? low_status : high_status;
    assign level_ok     = (level == (is_high ? LEVEL_TOP : '0));
    assign move_en      = (state == MOVE_EMPTY) || (state == MOVE_FULL);

    lock_controller_level_timer #(
        .LEVEL_W     (LEVEL_W),
        .LEVEL_MAX   (LEVEL_MAX),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_level_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (move_en),
        .dir       (!is_high),
        .level     (level),
        .at_target (at_target)
    );

`ifdef TIMEOUT_EN
    localparam int TW = $clog2(ENTER_TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(ENTER_TIMEOUT - 1);
    logic [TW-1:0] wait_cnt;
    logic          timeout_hit;
`endif

    always_comb begin
        state_next   = state;
        at_high_next = at_high;
        open_cur     = 1'b0;
        close_cur    = 1'b0;
        close_other  = 1'b0;
`ifdef TIMEOUT_EN
        timeout_hit  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (is_high ? down_req : up_req)       state_next = OPEN_IN;
                else if (is_high ? up_req : down_req)  state_next = MOVE_EMPTY;
            end
            MOVE_EMPTY, MOVE_FULL: begin
                if (at_target) begin
                    at_high_next = !at_high;
                    state_next   = (state == MOVE_EMPTY) ? OPEN_IN : OPEN_OUT;
                end
            end
            OPEN_IN, OPEN_OUT: begin
                // Interlock: the far gate must read closed before ours may open.
                if (!other_status)   close_other = 1'b1;
                else if (!cur_status) state_next = (state == OPEN_IN) ? WAIT_IN : WAIT_OUT;
                else                 open_cur    = level_ok;
            end
            WAIT_IN: begin
                if (occupied) state_next = CLOSE_IN;
`ifdef TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_next  = CLOSE_OUT;
                    timeout_hit = 1'b1;
                end
`endif
            end
            WAIT_OUT: begin
                if (!occupied) state_next = CLOSE_OUT;
            end
            CLOSE_IN, CLOSE_OUT: begin
                if (cur_status) state_next = (state == CLOSE_IN) ? MOVE_FULL : IDLE;
                else            close_cur  = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate commands are registered from the current state, so they rise one
    // cycle after a state is entered and fall one cycle after status confirms.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            at_high    <= SIDE_LOW;
            low_open   <= 1'b0;
            low_close  <= 1'b0;
            high_open  <= 1'b0;
            high_close <= 1'b0;
        end else begin
            state      <= state_next;
            at_high    <= at_high_next;
            low_open   <= !is_high && open_cur;
            low_close  <= (!is_high && close_cur) || (is_high && close_other);
            high_open  <= is_high && open_cur;
            high_close <= (is_high && close_cur) || (!is_high && close_other);
        end
    end

`ifdef TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset || state != WAIT_IN) wait_cnt <= '0;
        else                           wait_cnt <= wait_cnt + TW'(1);
    end
    assign timeout = timeout_hit;
`else
    assign timeout = 1'b0;
`endif

    assign busy        = (state != IDLE);
    assign dbg_state   = state;
    assign dbg_at_high = at_high;

endmodule

// File: tb/tb_lock_controller.sv
// Bench for lock_controller: two door models close the loop, the boat is driven
// directly. Define TIMEOUT_EN to exercise the enter-timeout build.
module tb_lock_controller;
    import lock_controller_pkg::*;

    localparam int LEVEL_W     = 4;
    localparam int LEVEL_MAX   = 8;
    localparam int STEP_CYCLES = 4;

    logic         clk, reset;
    logic         up_req, down_req, occupied;
    logic         low_status, high_status;
    logic         low_open, low_close, high_open, high_close;
    logic [3:0]   level;
    logic         busy, timeout;
    logic [3:0]   dbg_state;
    logic         dbg_at_high;

    logic         low_st, high_st, high_force;
    int           checks = 0;
    int           errors = 0;
    int           viol_count = 0;
    int           n;
    logic         seen_to;

    lock_controller #(
        .LEVEL_W     (LEVEL_W),
        .LEVEL_MAX   (LEVEL_MAX),
        .STEP_CYCLES (STEP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .up_req      (up_req),
        .down_req    (down_req),
        .occupied    (occupied),
        .low_status  (low_status),
        .high_status (high_status),
        .low_open    (low_open),
        .low_close   (low_close),
        .high_open   (high_open),
        .high_close  (high_close),
        .level       (level),
        .busy        (busy),
        .timeout     (timeout),
        .dbg_state   (dbg_state),
        .dbg_at_high (dbg_at_high)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Door models: one cycle to follow a command; high door can be held open.
    always_ff @(posedge clk) begin
        if (reset)          low_st <= 1'b1;
        else if (low_open)  low_st <= 1'b0;
        else if (low_close) low_st <= 1'b1;
    end
    always_ff @(posedge clk) begin
        if (reset)           high_st <= 1'b1;
        else if (high_open)  high_st <= 1'b0;
        else if (high_close) high_st <= 1'b1;
    end
    assign low_status  = low_st;
    assign high_status = high_force ? 1'b0 : high_st;

    // Interlock monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if ((low_open && low_close) || (high_open && high_close) ||
                (low_open && !(high_status && level == 4'd0)) ||
                (high_open && !(low_status && level == 4'd8))) begin
                viol_count++;
                $display("FAIL interlock at %0t: lo=%0b lc=%0b ho=%0b hc=%0b ls=%0b hs=%0b lvl=%0d",
                         $time, low_open, low_close, high_open, high_close,
                         low_status, high_status, level);
            end
        end
    end

    // Driver tasks
    task automatic tick(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        up_req     = 1'b0;
        down_req   = 1'b0;
        occupied   = 1'b0;
        high_force = 1'b0;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string name);
        int k = 0;
        while (dbg_state !== s && k < budget) begin
            tick(1);
            k++;
        end
        check(name, dbg_state, s);
    endtask

    // IDLE decision vectors from the low side
    typedef struct {
        logic       up;
        logic       down;
        logic [3:0] exp_state;
        logic       exp_busy;
        logic       exp_low_open;
        logic       exp_high_open;
    } vec_t;
    vec_t vecs[4];

    initial begin
        vecs[0] = '{up: 1'b0, down: 1'b0, exp_state: IDLE,       exp_busy: 1'b0, exp_low_open: 1'b0, exp_high_open: 1'b0};
        vecs[1] = '{up: 1'b1, down: 1'b0, exp_state: OPEN_IN,    exp_busy: 1'b1, exp_low_open: 1'b1, exp_high_open: 1'b0};
        vecs[2] = '{up: 1'b0, down: 1'b1, exp_state: MOVE_EMPTY, exp_busy: 1'b1, exp_low_open: 1'b0, exp_high_open: 1'b0};
        vecs[3] = '{up: 1'b1, down: 1'b1, exp_state: OPEN_IN,    exp_busy: 1'b1, exp_low_open: 1'b1, exp_high_open: 1'b0};

        do_reset();
        check("rst_state", dbg_state, IDLE);
        check("rst_level", level, 0);
        check("rst_at_high", dbg_at_high, 0);
        check("rst_busy", busy, 0);
        check("rst_cmds", {low_open, low_close, high_open, high_close}, 0);
        check("rst_timeout", timeout, 0);

        for (int i = 0; i < 4; i++) begin
            do_reset();
            up_req   = vecs[i].up;
            down_req = vecs[i].down;
            tick(1);
            check($sformatf("vec%0d_state", i), dbg_state, vecs[i].exp_state);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
            tick(1);
            check($sformatf("vec%0d_low_open", i), low_open, vecs[i].exp_low_open);
            check($sformatf("vec%0d_high_open", i), high_open, vecs[i].exp_high_open);
            check($sformatf("vec%0d_level", i), level, 0);
        end

        // 1) Up passage
        do_reset();
        up_req = 1'b1;
        tick(1);
        check("up_open_in", dbg_state, OPEN_IN);
        check("up_low_open_lat0", low_open, 0);
        tick(1);
        check("up_low_open_lat1", low_open, 1);
        wait_state(WAIT_IN, 10, "up_wait_in");
        check("up_low_open_drop", low_open, 0);
        check("up_low_gate_open", low_status, 0);
        up_req   = 1'b0;
        occupied = 1'b1;
        tick(1);
        check("up_close_in", dbg_state, CLOSE_IN);
        tick(1);
        check("up_low_close", low_close, 1);
        wait_state(MOVE_FULL, 10, "up_move_full");
        check("up_level_start", level, 0);
        n = 0;
        while (level != 4'd8 && n < 100) begin
            tick(1);
            n++;
        end
        check("up_fill_cycles", n, 32);
        tick(1);
        check("up_open_out", dbg_state, OPEN_OUT);
        check("up_at_high", dbg_at_high, 1);
        tick(1);
        check("up_high_open", high_open, 1);
        wait_state(WAIT_OUT, 10, "up_wait_out");
        occupied = 1'b0;
        wait_state(IDLE, 20, "up_idle");
        check("up_end_at_high", dbg_at_high, 1);
        check("up_end_level", level, 8);
        check("up_end_high_closed", high_status, 1);
        check("up_end_busy", busy, 0);

        // 2) Down request while idle low: empty fill first
        do_reset();
        down_req = 1'b1;
        tick(1);
        check("dn_move_empty", dbg_state, MOVE_EMPTY);
        n = 0;
        while (level != 4'd8 && n < 100) begin
            tick(1);
            n++;
        end
        check("dn_fill_cycles", n, 32);
        tick(1);
        check("dn_open_in", dbg_state, OPEN_IN);
        tick(1);
        check("dn_high_open", high_open, 1);
        check("dn_low_open", low_open, 0);
        wait_state(WAIT_IN, 10, "dn_wait_in");
        down_req = 1'b0;
        occupied = 1'b1;
        wait_state(MOVE_FULL, 10, "dn_move_full");
        n = 0;
        while (level != 4'd0 && n < 100) begin
            tick(1);
            n++;
        end
        check("dn_drain_cycles", n, 32);
        wait_state(WAIT_OUT, 10, "dn_wait_out");
        check("dn_low_gate_open", low_status, 0);
        occupied = 1'b0;
        wait_state(IDLE, 20, "dn_idle");
        check("dn_end_level", level, 0);
        check("dn_end_at_high", dbg_at_high, 0);

        // 3) Both requests: same side first, then the other without an empty move
        do_reset();
        up_req   = 1'b1;
        down_req = 1'b1;
        tick(1);
        check("both_first_open_in", dbg_state, OPEN_IN);
        wait_state(WAIT_IN, 10, "both_wait_in1");
        up_req   = 1'b0;
        occupied = 1'b1;
        wait_state(WAIT_OUT, 80, "both_wait_out1");
        occupied = 1'b0;
        wait_state(IDLE, 20, "both_idle1");
        check("both_at_high1", dbg_at_high, 1);
        tick(1);
        check("both_second_open_in", dbg_state, OPEN_IN);
        tick(1);
        check("both_second_high_open", high_open, 1);
        wait_state(WAIT_IN, 10, "both_wait_in2");
        down_req = 1'b0;
        occupied = 1'b1;
        wait_state(WAIT_OUT, 80, "both_wait_out2");
        occupied = 1'b0;
        wait_state(IDLE, 20, "both_idle2");
        check("both_end_level", level, 0);
        check("both_end_at_high", dbg_at_high, 0);

        // 4) Reset mid-fill
        do_reset();
        up_req = 1'b1;
        wait_state(WAIT_IN, 10, "rmid_wait_in");
        up_req   = 1'b0;
        occupied = 1'b1;
        wait_state(MOVE_FULL, 10, "rmid_move_full");
        n = 0;
        while (level != 4'd5 && n < 100) begin
            tick(1);
            n++;
        end
        check("rmid_level5", level, 5);
        reset = 1'b1;
        tick(1);
        check("rmid_level", level, 0);
        check("rmid_busy", busy, 0);
        check("rmid_state", dbg_state, IDLE);
        check("rmid_cmds", {low_open, low_close, high_open, high_close}, 0);
        reset    = 1'b0;
        occupied = 1'b0;

        // 5) Far gate reads open during OPEN_IN
        do_reset();
        high_force = 1'b1;
        up_req     = 1'b1;
        tick(2);
        check("far_high_close", high_close, 1);
        check("far_low_open_held", low_open, 0);
        tick(5);
        check("far_still_open_in", dbg_state, OPEN_IN);
        check("far_high_close_held", high_close, 1);
        check("far_low_open_still0", low_open, 0);
        high_force = 1'b0;
        tick(1);
        check("far_low_open_after", low_open, 1);
        check("far_high_close_drop", high_close, 0);

`ifdef TIMEOUT_EN
        // 6) Boat never enters
        do_reset();
        up_req = 1'b1;
        wait_state(WAIT_IN, 10, "to_wait_in");
        up_req = 1'b0;
        n = 1;
        while (timeout !== 1'b1 && n < 200) begin
            tick(1);
            n++;
        end
        check("to_pulse_cycle", n, 64);
        tick(1);
        check("to_close_out", dbg_state, CLOSE_OUT);
        check("to_pulse_width", timeout, 0);
        wait_state(IDLE, 20, "to_idle");
        check("to_level", level, 0);
        check("to_low_closed", low_status, 1);
`else
        // 6) Without the timeout build, WAIT_IN holds indefinitely
        do_reset();
        up_req = 1'b1;
        wait_state(WAIT_IN, 10, "nto_wait_in");
        up_req  = 1'b0;
        seen_to = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick(1);
            seen_to = seen_to | timeout;
        end
        check("nto_no_pulse", seen_to, 0);
        check("nto_still_wait_in", dbg_state, WAIT_IN);
`endif

        check("interlock_violations", viol_count, 0);

        // Final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
